fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID latch. It owns the PC, holds each
// icache request until ihit, buffers one instruction across load-use stalls,
// queues redirects that arrive during a miss, and stops fetching on halt.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              halt_in,
  output logic              fd_enable,
  output logic              fd_flush,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] next_addr,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH,
    BUFFERED,
    REDIR_WAIT,
    HALT_WAIT,
    HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  logic [WORD_W-1:0] target;
  logic [WORD_W-1:0] pc_plus4;

  assign target   = redirect_addr & ~WORD_W'(3);
  assign pc_plus4 = pc_q + WORD_W'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      pc_q      <= WORD_W'(PC_INIT);
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    pend_d    = pend_q;
    fd_enable = 1'b0;
    fd_flush  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (halt_in) begin
          fd_flush = 1'b1;
          state_d  = ihit ? HALT : HALT_WAIT;
        end else if (redirect) begin
          fd_flush = 1'b1;
          if (ihit) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = REDIR_WAIT;
          end
        end else if (ihit) begin
          if (stall) begin
            buf_d     = imemload;
            buf_vld_d = 1'b1;
            state_d   = BUFFERED;
          end else begin
            fd_enable = 1'b1;
            pc_d      = pc_plus4;
          end
        end
      end

      BUFFERED: begin
        if (halt_in) begin
          fd_flush  = 1'b1;
          buf_vld_d = 1'b0;
          state_d   = HALT;
        end else if (redirect) begin
          fd_flush  = 1'b1;
          buf_vld_d = 1'b0;
          pc_d      = target;
          state_d   = FETCH;
        end else if (!stall) begin
          fd_enable = 1'b1;
          buf_vld_d = 1'b0;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end

      REDIR_WAIT: begin
        if (halt_in) begin
          fd_flush = 1'b1;
          state_d  = ihit ? HALT : HALT_WAIT;
        end else begin
          // A redirect arriving together with ihit is the newest target and wins.
          if (redirect) begin
            fd_flush = 1'b1;
            pend_d   = target;
          end
          if (ihit) begin
            pc_d    = redirect ? target : pend_q;
            state_d = FETCH;
          end
        end
      end

      HALT_WAIT: begin
        fd_flush = halt_in;
        if (ihit) state_d = HALT;
      end

      HALT: begin
      end

      default: state_d = FETCH;
    endcase
  end

  assign imemREN   = nRST && (state_q == FETCH || state_q == REDIR_WAIT ||
                              state_q == HALT_WAIT);
  assign imemaddr  = pc_q;
  assign instr_out = (state_q == BUFFERED && buf_vld_q) ? buf_q : imemload;
  assign pc_out    = pc_q;
  assign next_addr = pc_plus4;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each step drives inputs, then checks outputs
// against hand-computed values with immediate assertions.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt_in;
  logic        fd_enable;
  logic        fd_flush;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] next_addr;
  logic        halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .halt_in(halt_in),
    .fd_enable(fd_enable), .fd_flush(fd_flush),
    .instr_out(instr_out), .pc_out(pc_out), .next_addr(next_addr),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = '0; stall = 1'b0;
    redirect = 1'b0; redirect_addr = '0; halt_in = 1'b0;
    #1;
    chk("rst_imemREN", 32'(imemREN), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_enable", 32'(fd_enable), 32'd0);
    chk("rst_flush", 32'(fd_flush), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    tick(); tick();
    nRST = 1'b1;

    // streaming with ihit every cycle
    ihit = 1'b1; imemload = 32'h1111_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_pc", pc_out, 32'(4 * i));
      chk("seq_next", next_addr, 32'(4 * i + 4));
      chk("seq_enable", 32'(fd_enable), 32'd1);
      chk("seq_imemREN", 32'(imemREN), 32'd1);
      tick();
    end

    // three-cycle miss at 0x10
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_addr", imemaddr, 32'h10);
      chk("miss_enable", 32'(fd_enable), 32'd0);
      tick();
    end
    ihit = 1'b1; #1;
    chk("miss_hit_enable", 32'(fd_enable), 32'd1);
    tick();
    chk("miss_pc_after", pc_out, 32'h14);
    tick(); tick(); tick();
    chk("pc_at_20", pc_out, 32'h20);

    // load-use stall with buffered instruction
    stall = 1'b1; imemload = 32'hDEAD_BEEF; #1;
    chk("stall_enable", 32'(fd_enable), 32'd0);
    tick();
    imemload = 32'h0; #1;
    chk("buf_imemREN", 32'(imemREN), 32'd0);
    tick();
    stall = 1'b0; #1;
    chk("buf_enable", 32'(fd_enable), 32'd1);
    chk("buf_instr", instr_out, 32'hDEAD_BEEF);
    chk("buf_pc", pc_out, 32'h20);
    tick();
    chk("buf_pc_after", pc_out, 32'h24);
    chk("buf_fetch_REN", 32'(imemREN), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("pc_at_40", pc_out, 32'h40);

    // redirects during a miss: latest target wins
    ihit = 1'b0; redirect = 1'b1; redirect_addr = 32'h103; #1;
    chk("rd1_flush", 32'(fd_flush), 32'd1);
    chk("rd1_enable", 32'(fd_enable), 32'd0);
    tick();
    redirect_addr = 32'h200; #1;
    chk("rd2_flush", 32'(fd_flush), 32'd1);
    chk("rd2_addr", imemaddr, 32'h40);
    tick();
    redirect = 1'b0; #1;
    chk("rdw_addr", imemaddr, 32'h40);
    chk("rdw_flush", 32'(fd_flush), 32'd0);
    chk("rdw_REN", 32'(imemREN), 32'd1);
    tick();
    ihit = 1'b1; #1;
    chk("rdw_hit_enable", 32'(fd_enable), 32'd0);
    tick();
    chk("rdw_pc", pc_out, 32'h200);

    // redirect + stall while buffered
    stall = 1'b1; imemload = 32'hCAFE_F00D; tick();
    redirect = 1'b1; redirect_addr = 32'h80; #1;
    chk("bred_flush", 32'(fd_flush), 32'd1);
    chk("bred_enable", 32'(fd_enable), 32'd0);
    tick();
    redirect = 1'b0; stall = 1'b0; ihit = 1'b0; imemload = 32'h1234_5678; #1;
    chk("bred_pc", pc_out, 32'h80);
    chk("bred_REN", 32'(imemREN), 32'd1);
    chk("bred_instr", instr_out, 32'h1234_5678);

    // PC wrap
    ihit = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFE; tick();
    redirect = 1'b0; #1;
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_next", next_addr, 32'h0);
    chk("wrap_enable", 32'(fd_enable), 32'd1);
    tick();
    chk("wrap_pc_after", pc_out, 32'h0);

    // halt during a miss
    ihit = 1'b0; halt_in = 1'b1; #1;
    chk("halt_flush", 32'(fd_flush), 32'd1);
    tick();
    halt_in = 1'b0; #1;
    chk("hw_REN", 32'(imemREN), 32'd1);
    chk("hw_halted", 32'(halted), 32'd0);
    chk("hw_enable", 32'(fd_enable), 32'd0);
    tick();
    ihit = 1'b1; #1;
    chk("hw_hit_enable", 32'(fd_enable), 32'd0);
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_REN", 32'(imemREN), 32'd0);
    chk("halt_enable", 32'(fd_enable), 32'd0);
    tick();
    chk("halt_pc_frozen", pc_out, 32'h0);
    chk("halt_stays", 32'(halted), 32'd1);

    // asynchronous reset exits halt
    #2 nRST = 1'b0; #1;
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_REN", 32'(imemREN), 32'd0);
    tick();
    nRST = 1'b1; #1;
    chk("post_rst_enable", 32'(fd_enable), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
